// File: rtl/window_sample_reader.sv
// Window sample buffer for the median-filter datapath: captures DEPTH samples
// in write order, then streams them to the sorter over a valid/ready handshake.
module window_sample_reader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 9,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    state_t                       state;
    logic [CNT_W-1:0]             wr_idx;
    logic [CNT_W-1:0]             rd_idx;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                         idle_full;
    logic                         wr_take;

    assign idle_full = (state == IDLE) && (wr_idx == DEPTH_C);
    assign wr_take   = (state == IDLE) && wr_en_i && !idle_full && !clear_i;

    // Sample storage carries no reset; only indices and state are reset.
    always_ff @(posedge CLK) begin
        if (wr_take)
            mem[wr_idx] <= wr_data_i;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            wr_idx <= '0;
            rd_idx <= '0;
        end else if (clear_i) begin
            state  <= IDLE;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A write while not full wins over a same-cycle start.
                    if (wr_en_i && !idle_full) begin
                        wr_idx <= wr_idx + 1'b1;
                    end else if (start_i && idle_full) begin
                        state  <= STREAM;
                        rd_idx <= '0;
                    end
                end
                STREAM: begin
                    if (rd_ready_i) begin
                        if (rd_idx == LAST_C) begin
                            state  <= DONE;
                            rd_idx <= '0;
                            wr_idx <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    wr_idx <= '0;
                    rd_idx <= '0;
                end
                default: begin
                    state  <= IDLE;
                    wr_idx <= '0;
                    rd_idx <= '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so rd_ready_i never reaches rd_valid_o.
    always_comb begin
        rd_valid_o = 1'b0;
        rd_data_o  = '0;
        full_o     = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        count_o    = '0;
        case (state)
            IDLE: begin
                full_o  = idle_full;
                count_o = wr_idx;
            end
            STREAM: begin
                rd_valid_o = 1'b1;
                rd_data_o  = mem[rd_idx];
                full_o     = 1'b1;
                busy_o     = 1'b1;
                count_o    = DEPTH_C - rd_idx;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_window_sample_reader.sv
// Directed bench for window_sample_reader: fill/stream, backpressure, overflow,
// writes during stream, synchronous clear and asynchronous reset mid-stream.
module tb_window_sample_reader;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       wr_en_i = 1'b0;
    logic [7:0] wr_data_i = '0;
    logic       start_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       rd_ready_i = 1'b0;
    logic       rd_valid_o;
    logic [7:0] rd_data_o;
    logic       full_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] count_o;

    int vectors = 0;
    int miscompares = 0;

    window_sample_reader #(.DATA_W(8), .DEPTH(9), .CNT_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .start_i    (start_i),
        .clear_i    (clear_i),
        .rd_ready_i (rd_ready_i),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .full_o     (full_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .count_o    (count_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] cnt, input logic full);
        chk({tag, " valid"}, 32'(rd_valid_o), 32'd0);
        chk({tag, " busy"},  32'(busy_o),     32'd0);
        chk({tag, " done"},  32'(done_o),     32'd0);
        chk({tag, " full"},  32'(full_o),     32'(full));
        chk({tag, " count"}, 32'(count_o),    32'(cnt));
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en_i   = 1'b1;
            wr_data_i = base + 8'(i);
            tick();
        end
        wr_en_i = 1'b0;
    endtask

    task automatic start_stream();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Ready held high: one sample per cycle, then the DONE pulse and back to IDLE.
    task automatic stream_all(input string tag, input logic [7:0] base);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk({tag, " valid"}, 32'(rd_valid_o), 32'd1);
            chk({tag, " busy"},  32'(busy_o),     32'd1);
            chk({tag, " full"},  32'(full_o),     32'd1);
            chk({tag, " data"},  32'(rd_data_o),  32'(base + 8'(i)));
            chk({tag, " count"}, 32'(count_o),    32'(9 - i));
            chk({tag, " done"},  32'(done_o),     32'd0);
            tick();
        end
        rd_ready_i = 1'b0;
        chk({tag, " done pulse"}, 32'(done_o),     32'd1);
        chk({tag, " done valid"}, 32'(rd_valid_o), 32'd0);
        chk({tag, " done busy"},  32'(busy_o),     32'd0);
        chk({tag, " done full"},  32'(full_o),     32'd0);
        chk({tag, " done count"}, 32'(count_o),    32'd0);
        tick();
        chk_idle({tag, " post"}, 4'd0, 1'b0);
    endtask

    initial begin
        // Reset held for two cycles
        RST = 1'b0;
        tick();
        tick();
        chk_idle("reset", 4'd0, 1'b0);
        chk("reset data", 32'(rd_data_o), 32'd0);
        #2 RST = 1'b1;
        tick();

        // Fill and stream
        fill(8'h10, 9);
        chk_idle("fill", 4'd9, 1'b1);
        rd_ready_i = 1'b1;
        start_stream();
        stream_all("stream", 8'h10);

        // Backpressure: ready pattern 1,0,0 repeating
        fill(8'h30, 9);
        start_stream();
        begin
            int k = 0;
            int c = 0;
            while (k < 9 && c < 100) begin
                chk("bp valid", 32'(rd_valid_o), 32'd1);
                chk("bp data",  32'(rd_data_o),  32'(8'h30 + 8'(k)));
                chk("bp count", 32'(count_o),    32'(9 - k));
                chk("bp done",  32'(done_o),     32'd0);
                rd_ready_i = (c % 3 == 0);
                tick();
                if (c % 3 == 0) k++;
                c++;
            end
            chk("bp handshakes", 32'(k), 32'd9);
        end
        rd_ready_i = 1'b0;
        chk("bp done pulse", 32'(done_o), 32'd1);
        tick();
        chk_idle("bp post", 4'd0, 1'b0);

        // Overflow and early start
        fill(8'h20, 5);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk_idle("early start", 4'd5, 1'b0);
        wr_en_i   = 1'b1;
        wr_data_i = 8'h25;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        wr_en_i = 1'b0;
        chk_idle("write+start", 4'd6, 1'b0);
        fill(8'h26, 6);
        chk_idle("overflow", 4'd9, 1'b1);
        start_stream();
        stream_all("ovf stream", 8'h20);

        // Writes during stream are ignored, including in the DONE cycle
        fill(8'h40, 9);
        start_stream();
        wr_en_i   = 1'b1;
        wr_data_i = 8'hFF;
        rd_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("wds data",  32'(rd_data_o), 32'(8'h40 + 8'(i)));
            chk("wds count", 32'(count_o),   32'(9 - i));
            tick();
        end
        rd_ready_i = 1'b0;
        chk("wds done", 32'(done_o), 32'd1);
        tick();
        wr_en_i = 1'b0;
        chk_idle("wds post", 4'd0, 1'b0);

        // Synchronous clear after the 4th handshake
        fill(8'h50, 9);
        start_stream();
        rd_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("clr pre data", 32'(rd_data_o), 32'h54);
        clear_i = 1'b1;
        tick();
        clear_i    = 1'b0;
        rd_ready_i = 1'b0;
        chk_idle("clear", 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("clr no done", 32'(done_o), 32'd0);
        end
        fill(8'h60, 9);
        chk_idle("clr refill", 4'd9, 1'b1);
        start_stream();
        stream_all("clr stream", 8'h60);

        // Asynchronous reset mid-stream, between clock edges
        fill(8'h70, 9);
        start_stream();
        rd_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_ready_i = 1'b0;
        chk("arst pre data", 32'(rd_data_o), 32'h73);
        #2 RST = 1'b0;
        #1;
        chk_idle("arst", 4'd0, 1'b0);
        chk("arst data", 32'(rd_data_o), 32'd0);
        tick();
        #2 RST = 1'b1;
        tick();
        chk_idle("arst release", 4'd0, 1'b0);
        fill(8'h80, 9);
        chk_idle("arst refill", 4'd9, 1'b1);
        start_stream();
        stream_all("arst stream", 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/window_sample_reader.md
Name: window_sample_reader

Overview:
- Read-side companion to the 4-bit write-index counter in the median-filter datapath.
- Captures DEPTH pixel samples written sequentially by the window-fill logic.
- On command, streams the samples out in write order to the median sorter over a valid/ready handshake.
- Reports fill level and the remaining read count, and pulses completion when drained.

Parameters:
- DATA_W, 8, pixel sample width in bits
- DEPTH, 9, samples per window (3x3); legal range 2..15
- CNT_W, 4, width of index/count signals; must satisfy 2^CNT_W > DEPTH

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  asynchronous, active-low reset
- wr_en_i  input  1  write strobe: store wr_data_i at next write index
- wr_data_i  input  DATA_W  sample to store
- start_i  input  1  begin streaming; honoured only when full_o=1 in IDLE
- clear_i  input  1  synchronous abort/clear, highest priority after RST
- rd_ready_i  input  1  sorter can accept a sample
- rd_valid_o  output  1  rd_data_o holds a valid sample
- rd_data_o  output  DATA_W  current sample
- full_o  output  1  DEPTH samples stored
- busy_o  output  1  streaming in progress (STREAM state)
- done_o  output  1  one-cycle pulse after the last sample handshakes
- count_o  output  CNT_W  IDLE: samples stored; STREAM: samples not yet accepted

Behaviour:
- Reset (RST=0, async): state=IDLE, wr_idx=0, rd_idx=0; all outputs 0 (rd_data_o=0, count_o=0). Storage contents need not be cleared.
- States: IDLE, STREAM, DONE.
- IDLE:
  - wr_en_i=1 and full_o=0: store sample at wr_idx; wr_idx+1.
  - full_o = (wr_idx==DEPTH). wr_en_i while full_o=1 is ignored; no overwrite, no wrap.
  - count_o=wr_idx.
  - start_i=1 and full_o=1: go to STREAM; rd_idx=0.
  - start_i while not full is ignored.
  - wr_en_i and start_i in the same cycle while not full: write taken, start ignored.
- STREAM:
  - busy_o=1, rd_valid_o=1, rd_data_o=storage[rd_idx].
  - First sample is visible the cycle after start_i is sampled (latency 1).
  - Handshake = rd_valid_o & rd_ready_i at the rising edge; advances rd_idx.
  - With rd_ready_i held high: one sample per cycle, back-to-back.
  - rd_ready_i=0: rd_data_o and rd_valid_o held stable.
  - count_o = DEPTH - rd_idx.
  - wr_en_i and start_i are ignored; full_o stays 1.
  - Handshake when rd_idx==DEPTH-1: go to DONE.
- DONE (exactly 1 cycle):
  - done_o=1, rd_valid_o=0, busy_o=0, count_o=0, full_o=0.
  - wr_idx=0, rd_idx=0; go to IDLE.
  - wr_en_i in the DONE cycle is ignored.
- clear_i=1 (any state): next state IDLE; wr_idx=0, rd_idx=0; rd_valid_o, busy_o, done_o, full_o, count_o all 0 next cycle.
  - clear_i overrides wr_en_i, start_i and handshakes in the same cycle.
- RST asserted mid-stream: outputs go to reset values immediately, without waiting for a clock edge.
- All outputs are registered, or decoded from registered state only; no combinational path from rd_ready_i to rd_valid_o.

Test Plan:
- Fill and stream: RST low 2 cycles, then high; write 8'h10..8'h18 on 9 consecutive cycles -> full_o=1, count_o=9. Pulse start_i with rd_ready_i=1 -> rd_data_o=8'h10..8'h18 on 9 consecutive cycles with count_o 9..1. Then done_o=1 for 1 cycle; then full_o=0, count_o=0.
- Backpressure: stream with rd_ready_i toggling 1,0,0,1,... -> each sample held stable while ready=0; all 9 samples delivered once each, in order; done_o after the 9th handshake only.
- Overflow/ignore: write 12 samples 8'h20..8'h2B -> count_o saturates at 9, full_o=1; stream yields 8'h20..8'h28. start_i after 5 writes -> busy_o stays 0.
- Writes during stream: wr_en_i=1 with 8'hFF throughout STREAM -> no 8'hFF output; after done_o, count_o=0.
- Synchronous clear: clear_i=1 after the 4th handshake -> next cycle rd_valid_o=0, busy_o=0, count_o=0, done_o never pulses. A fresh 9-sample fill then streams correctly.
- Async reset mid-stream: RST=0 between clock edges during STREAM -> rd_valid_o, busy_o, count_o go to 0 immediately. After release, a full fill/stream cycle works.
